// File: rtl/sp_pkg.sv
// sp_pkg: shared state encoding and default parameters for the serial-to-parallel aligner.
package sp_pkg;

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        SYNC_CHECK = 2'd1,
        LOCKED     = 2'd2
    } sp_state_t;

    localparam int         SP_WIDTH      = 8;
    localparam logic [7:0] SP_SYNC_WORD  = 8'hBC;
    localparam int         SP_LOCK_COUNT = 4;

endpackage

// File: rtl/sp_sync_fsm.sv
// sp_sync_fsm: hunt / sync-check / locked sequencing with the word-boundary bit counter.
module sp_sync_fsm
    import sp_pkg::*;
#(
    parameter int WIDTH      = SP_WIDTH,
    parameter int LOCK_COUNT = SP_LOCK_COUNT
) (
    input  logic clk_8f,
    input  logic reset,
    input  logic match_i,
    input  logic resync_i,
    output logic boundary_o,
    output logic locked_o
);

    localparam int BW = $clog2(WIDTH);
    localparam int MW = $clog2(LOCK_COUNT + 1);

    sp_state_t       state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [MW-1:0]   match_cnt_q, match_cnt_d;

    assign boundary_o = bit_cnt_q == BW'(WIDTH - 1);
    assign locked_o   = state_q == LOCKED;

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        bit_cnt_d   = boundary_o ? '0 : bit_cnt_q + 1'b1;
        if (resync_i) begin
            state_d     = HUNT;
            match_cnt_d = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (match_i) begin
                        bit_cnt_d   = '0;
                        match_cnt_d = MW'(1);
                        state_d     = (LOCK_COUNT == 1) ? LOCKED : SYNC_CHECK;
                    end
                end
                SYNC_CHECK: begin
                    if (boundary_o && match_i) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        state_d     = (match_cnt_d == MW'(LOCK_COUNT)) ? LOCKED : SYNC_CHECK;
                    end else if (boundary_o) begin
                        match_cnt_d = '0;
                        state_d     = HUNT;
                    end
                end
                LOCKED: ;
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end

endmodule

// File: rtl/serie_paralelo_sync.sv
// serie_paralelo_sync: bit-rate serial-to-parallel converter with sync-word alignment and lock.
// Define SP_DROP_IDLE_EN to suppress delivery of sync words seen at boundaries while locked.
module serie_paralelo_sync
    import sp_pkg::*;
#(
    parameter int               WIDTH      = SP_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(SP_SYNC_WORD),
    parameter int               LOCK_COUNT = SP_LOCK_COUNT
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    input  logic             resync,
    output logic             valid_out_c,
    output logic [WIDTH-1:0] parallel_out_c,
    output logic             locked_out
);

    localparam int FW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_q, next_word, par_q, par_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             valid_q, valid_d;
    logic             is_sync, match, boundary, locked, idle, deliver;

    assign next_word = {shift_q[WIDTH-2:0], data_in};
    assign is_sync   = next_word == SYNC_WORD;
    // The current bit completes the window once WIDTH-1 bits are already held.
    assign match     = is_sync && (fill_q >= FW'(WIDTH - 1));

`ifdef SP_DROP_IDLE_EN
    assign idle = is_sync;
`else
    assign idle = 1'b0;
`endif

    sp_sync_fsm #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_fsm (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .match_i    (match),
        .resync_i   (resync),
        .boundary_o (boundary),
        .locked_o   (locked)
    );

    always_comb begin
        fill_d  = (fill_q == FW'(WIDTH)) ? fill_q : fill_q + 1'b1;
        deliver = locked && boundary && !resync && !idle;
        valid_d = deliver;
        par_d   = deliver ? next_word : par_q;
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            par_q   <= '0;
        end else begin
            shift_q <= next_word;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            par_q   <= par_d;
        end
    end

    assign valid_out_c    = valid_q;
    assign parallel_out_c = par_q;
    assign locked_out     = locked;

endmodule

// File: tb/tb_serie_paralelo_sync.sv
// tb_serie_paralelo_sync: directed and randomized checks against a bit-position reference model.
module tb_serie_paralelo_sync;

    localparam int         W    = 8;
    localparam logic [7:0] SYNC = 8'hBC;
    localparam int         LC   = 4;
`ifdef SP_DROP_IDLE_EN
    localparam bit IDLE = 1'b1;
`else
    localparam bit IDLE = 1'b0;
`endif

    logic       clk_8f = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b0;
    logic       resync = 1'b0;
    logic       valid_out_c, locked_out;
    logic [7:0] parallel_out_c;

    int checks = 0;
    int passed = 0;

    always #5 clk_8f = ~clk_8f;

    serie_paralelo_sync dut (
        .clk_8f         (clk_8f),
        .reset          (reset),
        .data_in        (data_in),
        .resync         (resync),
        .valid_out_c    (valid_out_c),
        .parallel_out_c (parallel_out_c),
        .locked_out     (locked_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: bits counted since reset; boundaries are whole words after the last hunt match.
    int         n, mode, cnt, anchor;
    logic [7:0] win, m_par;
    logic       m_valid, m_locked;

    always @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            n = 0; mode = 0; cnt = 0; anchor = 0; win = 0;
            m_valid = 0; m_par = 0; m_locked = 0;
        end else begin
            n++;
            win = {win[6:0], data_in};
            m_valid = 0;
            if (resync) begin
                mode = 0; cnt = 0;
            end else if (mode == 0) begin
                if (n >= W && win == SYNC) begin
                    anchor = n; cnt = 1; mode = (LC == 1) ? 2 : 1;
                end
            end else if ((n - anchor) % W == 0) begin
                if (mode == 1) begin
                    if (win == SYNC) begin
                        cnt++;
                        if (cnt == LC) mode = 2;
                    end else begin
                        mode = 0; cnt = 0;
                    end
                end else if (!(IDLE && win == SYNC)) begin
                    m_valid = 1; m_par = win;
                end
            end
            m_locked = mode == 2;
        end
    end

    always @(negedge clk_8f) begin
        if (!reset) begin
            chk("valid", valid_out_c, m_valid);
            chk("parallel", parallel_out_c, m_par);
            chk("locked", locked_out, m_locked);
        end
    end

    task automatic send_bit(input logic d, input logic rs);
        @(negedge clk_8f);
        data_in = d;
        resync = rs;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] rsm);
        for (int i = 7; i >= 0; i--) send_bit(b[i], rsm[i]);
    endtask

    task automatic after_edge;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk_8f);
        reset = 1'b1; data_in = 1'b0; resync = 1'b0;
        @(negedge clk_8f);
        reset = 1'b0;
    endtask

    initial begin
        int k;
        logic [7:0] b, rsm;
        repeat (2) @(negedge clk_8f);
        chk("reset_valid", valid_out_c, 0);
        chk("reset_par", parallel_out_c, 0);
        chk("reset_locked", locked_out, 0);
        reset = 1'b0;

        repeat (3) send_byte(SYNC, 8'h00);
        after_edge();
        chk("pre_lock", locked_out, 0);
        send_byte(SYNC, 8'h00);
        after_edge();
        chk("lock_rise", locked_out, 1);
        send_byte(8'h5A, 8'h00);
        after_edge();
        chk("first_valid", valid_out_c, 1);
        chk("first_word", parallel_out_c, 8'h5A);
        send_byte(8'hC3, 8'h00);
        after_edge();
        chk("second_valid", valid_out_c, 1);
        chk("second_word", parallel_out_c, 8'hC3);

        k = 0;
        send_byte(8'hA5, 8'h00); after_edge(); k += int'(valid_out_c);
        send_byte(SYNC, 8'h00);  after_edge(); k += int'(valid_out_c);
        send_byte(8'h3C, 8'h00); after_edge(); k += int'(valid_out_c);
        chk("idle_strobes", k, IDLE ? 2 : 3);

        send_byte(8'h77, 8'h01);
        after_edge();
        chk("resync_valid", valid_out_c, 0);
        chk("resync_locked", locked_out, 0);
        chk("resync_hold", parallel_out_c, 8'h3C);
        repeat (4) send_byte(SYNC, 8'h00);
        after_edge();
        chk("relock", locked_out, 1);

        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", valid_out_c, 0);
        chk("areset_par", parallel_out_c, 0);
        chk("areset_locked", locked_out, 0);
        @(negedge clk_8f);
        reset = 1'b0;

        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
        repeat (3) send_byte(SYNC, 8'h00);
        after_edge();
        chk("shifted_prelock", locked_out, 0);
        send_byte(SYNC, 8'h00);
        send_byte(8'h11, 8'h00);
        after_edge();
        chk("shifted_valid", valid_out_c, 1);
        chk("shifted_word", parallel_out_c, 8'h11);

        do_reset();
        send_byte(SYNC, 8'h00); send_byte(SYNC, 8'h00); send_byte(8'h00, 8'h00);
        after_edge();
        chk("broken_unlocked", locked_out, 0);
        repeat (4) send_byte(SYNC, 8'h00);
        after_edge();
        chk("broken_relock", locked_out, 1);
        chk("broken_no_word", parallel_out_c, 0);

        repeat (25) begin
            repeat ($urandom_range(0, 11)) send_bit(1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(1, 5)) send_byte(SYNC, 8'h00);
            repeat ($urandom_range(2, 10)) begin
                b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
                rsm = 8'h00;
                if ($urandom_range(0, 5) == 0) rsm[$urandom_range(0, 7)] = 1'b1;
                send_byte(b, rsm);
            end
        end

        @(negedge clk_8f);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
